// File: rtl/dsi_hs_multilane_tx_if.sv
// Stream, control and serdes-side signals of the multi-lane DSI HS transmitter.
// The master side is the packet assembler; the slave side is the transmitter.
interface dsi_hs_multilane_tx_if #(
    parameter int LANES = 4,
    parameter int TMR_W = 8
);
    logic                  start_rqst;
    logic [8*LANES-1:0]    inp_data;
    logic                  inp_valid;
    logic                  inp_last;
    logic [LANES-1:0]      inp_keep;
    logic                  inp_ready;
    logic                  active;
    logic                  fin_ack;
    logic                  underflow_err;
    logic [TMR_W-1:0]      hs_go_timeout;
    logic [TMR_W-1:0]      hs_trail_timeout;
    logic [8*LANES-1:0]    hs_output;
    logic [LANES-1:0]      hs_enable;

    modport master (
        output start_rqst, inp_data, inp_valid, inp_last, inp_keep,
               hs_go_timeout, hs_trail_timeout,
        input  inp_ready, active, fin_ack, underflow_err, hs_output, hs_enable
    );

    modport slave (
        input  start_rqst, inp_data, inp_valid, inp_last, inp_keep,
               hs_go_timeout, hs_trail_timeout,
        output inp_ready, active, fin_ack, underflow_err, hs_output, hs_enable
    );
endinterface

// File: rtl/dsi_hs_multilane_tx.sv
// Multi-lane DSI high-speed burst transmitter: HS-GO, SYNC, ACTIVE and TRAIL in
// lock-step on all lanes, with a per-lane trail timer so partial final beats trail early.
//
// state  | meaning
// IDLE   | HS drive off, waiting for start_rqst
// GO     | HS drive on, zero bytes for the HS-GO time
// SYNC   | one cycle emitting SYNC_SEQUENCE on every lane
// ACTIVE | one byte per lane per accepted beat
// TRAIL  | lanes repeat their trail byte until every lane's timer expires
module dsi_hs_multilane_tx #(
    parameter int         LANES         = 4,
    parameter logic [7:0] SYNC_SEQUENCE = 8'b00011101,
    parameter int         TMR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dsi_hs_multilane_tx_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_GO, S_SYNC, S_ACTIVE, S_TRAIL} state_t;

    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  go_cnt;
    logic [TMR_W-1:0]  trail_len;
    logic [TMR_W-1:0]  go_len_in;
    logic [TMR_W-1:0]  trail_len_in;
    logic [TMR_W-1:0]  trail_cnt [LANES];
    logic [7:0]        last_byte [LANES];
    logic [7:0]        hs_out_q  [LANES];
    logic [7:0]        lane_data [LANES];
    logic [7:0]        trail_byte[LANES];
    logic [LANES-1:0]  trailing;
    logic [LANES-1:0]  trail_done;
    logic [LANES-1:0]  trail_end;
    logic [LANES-1:0]  keep_eff;
    logic [LANES-1:0]  hs_en_q;
    logic              active_q;
    logic              fin_q;
    logic              underflow_q;
    logic              all_done_nxt;

    assign go_len_in    = (bus.hs_go_timeout    == '0) ? ONE : bus.hs_go_timeout;
    assign trail_len_in = (bus.hs_trail_timeout == '0) ? ONE : bus.hs_trail_timeout;
    assign keep_eff     = bus.inp_keep | LANES'(1);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_data[g]            = bus.inp_data[8*g +: 8];
        assign trail_byte[g]           = {8{~last_byte[g][0]}};
        assign bus.hs_output[8*g +: 8] = hs_out_q[g];
    end

    // A lane whose timer reads 1 drops HS drive on this edge.
    always_comb begin
        trail_end = '0;
        for (int i = 0; i < LANES; i++) begin
            trail_end[i] = trailing[i] && (trail_cnt[i] == ONE);
        end
    end

    assign all_done_nxt = &(trail_done | trail_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start_rqst) state_nxt = S_GO;
            S_GO:     if (go_cnt == ONE) state_nxt = S_SYNC;
            S_SYNC:   state_nxt = S_ACTIVE;
            S_ACTIVE: if (!bus.inp_valid || bus.inp_last) state_nxt = S_TRAIL;
            S_TRAIL:  if (all_done_nxt) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_cnt      <= '0;
            trail_len   <= '0;
            trailing    <= '0;
            trail_done  <= '0;
            hs_en_q     <= '0;
            active_q    <= 1'b0;
            fin_q       <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                trail_cnt[i] <= '0;
                last_byte[i] <= '0;
                hs_out_q[i]  <= '0;
            end
        end else begin
            fin_q       <= 1'b0;
            underflow_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_rqst) begin
                        go_cnt     <= go_len_in;
                        active_q   <= 1'b1;
                        trailing   <= '0;
                        trail_done <= '0;
                    end
                end
                S_GO: begin
                    go_cnt  <= go_cnt - ONE;
                    hs_en_q <= '1;
                    for (int i = 0; i < LANES; i++) begin
                        hs_out_q[i] <= '0;
                    end
                end
                S_SYNC: begin
                    for (int i = 0; i < LANES; i++) begin
                        hs_out_q[i]  <= SYNC_SEQUENCE;
                        last_byte[i] <= SYNC_SEQUENCE;
                    end
                end
                S_ACTIVE: begin
                    if (!bus.inp_valid || bus.inp_last) begin
                        trail_len <= trail_len_in;
                    end
                    underflow_q <= !bus.inp_valid;
                    // Starved cycle behaves as a final beat with no lanes kept.
                    for (int i = 0; i < LANES; i++) begin
                        if (bus.inp_valid && (!bus.inp_last || keep_eff[i])) begin
                            hs_out_q[i]  <= lane_data[i];
                            last_byte[i] <= lane_data[i];
                        end else begin
                            hs_out_q[i]  <= trail_byte[i];
                            trail_cnt[i] <= trail_len_in;
                            trailing[i]  <= 1'b1;
                        end
                    end
                end
                S_TRAIL: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (trail_end[i]) begin
                            hs_en_q[i]    <= 1'b0;
                            hs_out_q[i]   <= '0;
                            trailing[i]   <= 1'b0;
                            trail_done[i] <= 1'b1;
                        end else if (trailing[i]) begin
                            trail_cnt[i] <= trail_cnt[i] - ONE;
                        end else if (!trail_done[i]) begin
                            hs_out_q[i]  <= trail_byte[i];
                            trail_cnt[i] <= trail_len;
                            trailing[i]  <= 1'b1;
                        end
                    end
                    if (all_done_nxt) begin
                        fin_q    <= 1'b1;
                        active_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.inp_ready     = (state == S_ACTIVE);
    assign bus.active        = active_q;
    assign bus.fin_ack       = fin_q;
    assign bus.underflow_err = underflow_q;
    assign bus.hs_enable     = hs_en_q;
endmodule

// File: tb/tb_dsi_hs_multilane_tx.sv
// Bench for dsi_hs_multilane_tx: a per-cycle timeline model built from burst
// descriptions, compared every cycle, plus hand-computed literal spot checks.
module tb_dsi_hs_multilane_tx;
    localparam int LANES = 4;
    localparam int TMR_W = 8;
    localparam logic [7:0] SYNC = 8'h1D;
    localparam int MAXC = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    bit [8*LANES-1:0] e_out [MAXC];
    bit [LANES-1:0]   e_en  [MAXC];
    bit               e_act [MAXC];
    bit               e_fin [MAXC];
    bit               e_uf  [MAXC];
    bit               e_rdy [MAXC];
    logic [8*LANES-1:0] bdata [8];

    dsi_hs_multilane_tx_if #(.LANES(LANES), .TMR_W(TMR_W)) bus ();

    dsi_hs_multilane_tx #(
        .LANES(LANES), .SYNC_SEQUENCE(SYNC), .TMR_W(TMR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, got, want);
        end
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_clear(input int from);
        for (int c = from; c < MAXC; c++) begin
            e_out[c] = '0; e_en[c] = '0; e_act[c] = 0;
            e_fin[c] = 0;  e_uf[c] = 0;  e_rdy[c] = 0;
        end
    endtask

    // Timeline of one burst whose start is sampled at edge t0. Index c holds the
    // values visible between edge c and edge c+1.
    task automatic model_burst(input int t0, input int go, input int tr, input int nb,
                               input bit uf, input logic [LANES-1:0] keep, output int tf);
        int n, m, a;
        logic [7:0] lb [LANES];
        int off [LANES];
        logic [LANES-1:0] kf;
        logic [7:0] d;
        n  = (go == 0) ? 1 : go;
        m  = (tr == 0) ? 1 : tr;
        kf = keep | LANES'(1);
        for (int c = t0 + 1; c <= t0 + n; c++) e_out[c] = '0;
        for (int i = 0; i < LANES; i++) begin
            lb[i] = SYNC;
            off[i] = t0 + 1;
            e_out[t0+n+1][8*i +: 8] = SYNC;
        end
        for (int k = 0; k < nb; k++) begin
            a = t0 + n + 2 + k;
            e_rdy[a-1] = 1;
            for (int i = 0; i < LANES; i++) begin
                d = bdata[k][8*i +: 8];
                if (k < nb - 1 || uf) begin
                    e_out[a][8*i +: 8] = d;
                    lb[i] = d;
                end else if (kf[i]) begin
                    e_out[a][8*i +: 8] = d;
                    for (int j = 1; j <= m; j++) e_out[a+j][8*i +: 8] = {8{~d[0]}};
                    off[i] = a + 1 + m;
                end else begin
                    for (int j = 0; j < m; j++) e_out[a+j][8*i +: 8] = {8{~lb[i][0]}};
                    off[i] = a + m;
                end
            end
        end
        if (uf) begin
            a = t0 + n + 2 + nb;
            e_rdy[a-1] = 1;
            e_uf[a] = 1;
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < m; j++) e_out[a+j][8*i +: 8] = {8{~lb[i][0]}};
                off[i] = a + m;
            end
        end
        tf = 0;
        for (int i = 0; i < LANES; i++) begin
            for (int c = t0 + 1; c < off[i]; c++) e_en[c][i] = 1'b1;
            if (off[i] > tf) tf = off[i];
        end
        for (int c = t0; c < tf; c++) e_act[c] = 1;
        e_fin[tf] = 1;
    endtask

    task automatic drive_burst(input int t0, input int go, input int nb, input bit uf,
                               input logic [LANES-1:0] keep, input bit hold);
        int n;
        n = (go == 0) ? 1 : go;
        wait_cyc(t0 - 1);
        bus.start_rqst = 1'b1;
        wait_cyc(t0);
        if (!hold) bus.start_rqst = 1'b0;
        for (int k = 0; k < nb; k++) begin
            wait_cyc(t0 + n + 1 + k);
            bus.inp_valid = 1'b1;
            bus.inp_data  = bdata[k];
            bus.inp_last  = (k == nb - 1) && !uf;
            bus.inp_keep  = bus.inp_last ? keep : '1;
        end
        wait_cyc(t0 + n + 1 + nb);
        bus.inp_valid = 1'b0;
        bus.inp_last  = 1'b0;
        bus.inp_keep  = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("hs_output",     bus.hs_output,     e_out[cyc]);
            chk("hs_enable",     bus.hs_enable,     e_en[cyc]);
            chk("active",        bus.active,        e_act[cyc]);
            chk("fin_ack",       bus.fin_ack,       e_fin[cyc]);
            chk("underflow_err", bus.underflow_err, e_uf[cyc]);
            chk("inp_ready",     bus.inp_ready,     e_rdy[cyc]);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

    initial begin
        int t0, tf, tfa;
        bus.start_rqst = 1'b0;
        bus.inp_data   = '0;
        bus.inp_valid  = 1'b0;
        bus.inp_last   = 1'b0;
        bus.inp_keep   = '0;
        bus.hs_go_timeout    = 8'd3;
        bus.hs_trail_timeout = 8'd2;

        wait_cyc(3);
        chk("rst_hs_enable", bus.hs_enable, 0);
        chk("rst_hs_output", bus.hs_output, 0);
        chk("rst_active",    bus.active,    0);
        chk("rst_inp_ready", bus.inp_ready, 0);
        chk("rst_fin_ack",   bus.fin_ack,   0);
        rst = 1'b0;
        chk_en = 1'b1;

        // full single beat, go=3 trail=2
        bdata[0] = 32'h44332211;
        t0 = cyc + 2;
        model_burst(t0, 3, 2, 1, 1'b0, 4'hF, tf);
        drive_burst(t0, 3, 1, 1'b0, 4'hF, 1'b0);
        chk("t1_data", bus.hs_output, 32'h44332211);
        wait_cyc(t0 + 6);
        chk("t1_trail", bus.hs_output, 32'hFF00FF00);
        chk("t1_en", bus.hs_enable, 4'hF);
        wait_cyc(t0 + 8);
        chk("t1_en_off", bus.hs_enable, 4'h0);
        chk("t1_fin", bus.fin_ack, 1);
        wait_cyc(tf + 2);

        // partial final beat keep=0011
        bdata[0] = 32'h80808080;
        bdata[1] = 32'hDEAD5433;
        t0 = cyc + 2;
        model_burst(t0, 3, 2, 2, 1'b0, 4'b0011, tf);
        drive_burst(t0, 3, 2, 1'b0, 4'b0011, 1'b0);
        chk("t2_final", bus.hs_output, 32'hFFFF5433);
        wait_cyc(t0 + 7);
        chk("t2_trail", bus.hs_output, 32'hFFFFFF00);
        wait_cyc(t0 + 8);
        chk("t2_en_partial", bus.hs_enable, 4'b0011);
        chk("t2_out_partial", bus.hs_output, 32'h0000FF00);
        chk("t2_no_fin", bus.fin_ack, 0);
        wait_cyc(t0 + 9);
        chk("t2_fin", bus.fin_ack, 1);
        wait_cyc(tf + 2);

        // underflow on the first ACTIVE cycle, go=1 trail=3
        bus.hs_go_timeout    = 8'd1;
        bus.hs_trail_timeout = 8'd3;
        t0 = cyc + 2;
        model_burst(t0, 1, 3, 0, 1'b1, 4'h0, tf);
        drive_burst(t0, 1, 0, 1'b1, 4'h0, 1'b0);
        wait_cyc(t0 + 3);
        chk("t3_uf", bus.underflow_err, 1);
        chk("t3_trail", bus.hs_output, 32'h0);
        chk("t3_en", bus.hs_enable, 4'hF);
        wait_cyc(t0 + 4);
        chk("t3_uf_once", bus.underflow_err, 0);
        wait_cyc(t0 + 6);
        chk("t3_fin", bus.fin_ack, 1);
        wait_cyc(tf + 2);

        // zero timeouts behave as one cycle
        bus.hs_go_timeout    = 8'd0;
        bus.hs_trail_timeout = 8'd0;
        bdata[0] = 32'h12345678;
        t0 = cyc + 2;
        model_burst(t0, 0, 0, 1, 1'b0, 4'hF, tf);
        drive_burst(t0, 0, 1, 1'b0, 4'hF, 1'b0);
        chk("t4_data", bus.hs_output, 32'h12345678);
        wait_cyc(t0 + 4);
        chk("t4_trail", bus.hs_output, 32'hFFFFFFFF);
        wait_cyc(t0 + 5);
        chk("t4_fin", bus.fin_ack, 1);
        wait_cyc(tf + 2);

        // reset mid-ACTIVE
        bus.hs_go_timeout    = 8'd2;
        bus.hs_trail_timeout = 8'd3;
        bdata[0] = 32'hA1B2C3D4;
        bdata[1] = 32'h55667788;
        bdata[2] = 32'h99AABBCC;
        t0 = cyc + 2;
        model_burst(t0, 2, 3, 3, 1'b0, 4'hF, tf);
        wait_cyc(t0 - 1);
        bus.start_rqst = 1'b1;
        wait_cyc(t0);
        bus.start_rqst = 1'b0;
        wait_cyc(t0 + 3);
        chk("t5_sync", bus.hs_output, 32'h1D1D1D1D);
        bus.inp_valid = 1'b1;
        bus.inp_data  = bdata[0];
        bus.inp_last  = 1'b0;
        bus.inp_keep  = '1;
        wait_cyc(t0 + 4);
        chk("t5_data", bus.hs_output, 32'hA1B2C3D4);
        #1;
        rst = 1'b1;
        model_clear(cyc);
        bus.inp_valid = 1'b0;
        bus.inp_keep  = '0;
        #1;
        chk("t5_rst_en", bus.hs_enable, 0);
        chk("t5_rst_ready", bus.inp_ready, 0);
        chk("t5_rst_active", bus.active, 0);
        chk("t5_rst_output", bus.hs_output, 0);
        wait_cyc(cyc + 2);
        rst = 1'b0;

        // normal burst after reset, keep=0001
        bus.hs_trail_timeout = 8'd1;
        bdata[0] = 32'h01020304;
        bdata[1] = 32'hAABBCCDD;
        t0 = cyc + 2;
        model_burst(t0, 2, 1, 2, 1'b0, 4'b0001, tf);
        drive_burst(t0, 2, 2, 1'b0, 4'b0001, 1'b0);
        wait_cyc(tf + 2);

        // start held high: second burst starts on the fin_ack cycle
        bus.hs_go_timeout    = 8'd1;
        bus.hs_trail_timeout = 8'd1;
        bdata[0] = 32'hCAFEF00D;
        t0 = cyc + 2;
        model_burst(t0, 1, 1, 1, 1'b0, 4'hF, tfa);
        drive_burst(t0, 1, 1, 1'b0, 4'hF, 1'b1);
        bdata[0] = 32'h0BADBEEF;
        model_burst(tfa + 1, 1, 1, 1, 1'b0, 4'hF, tf);
        wait_cyc(tfa);
        chk("t6_fin", bus.fin_ack, 1);
        chk("t6_active_low", bus.active, 0);
        drive_burst(tfa + 1, 1, 1, 1'b0, 4'hF, 1'b0);
        wait_cyc(tf + 3);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
